// File: rtl/zxw_seq_div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, MSB first.
// Each trial subtraction reuses a ripple adder with an inverted divisor and carry-in of 1.
module zxw_seq_div #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state_reg, state_next;
  logic [N:0]      r_reg;
  logic [N-1:0]    q_reg, d_reg;
  logic [CW-1:0]   count_reg;
  logic            done_reg, dz_reg;
  logic [N-1:0]    quotient_reg, remainder_reg;

  logic [N:0]      r_shift, sub_b, trial;
  logic [N+1:0]    carry;
  logic            no_borrow, last_iter;

  // Partial remainder after shifting in the next dividend bit.
  assign r_shift = {r_reg[N-1:0], q_reg[N-1]};
  assign sub_b   = ~{1'b0, d_reg};
  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi <= N; gi++) begin : g_rca
      assign trial[gi]     = r_shift[gi] ^ sub_b[gi] ^ carry[gi];
      assign carry[gi + 1] = (r_shift[gi] & sub_b[gi]) | (carry[gi] & (r_shift[gi] ^ sub_b[gi]));
    end
  endgenerate

  assign no_borrow = carry[N+1];
  assign last_iter = (count_reg == CW'(N - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = (divisor != '0) ? RUN : FIN;
      RUN:  if (last_iter) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      r_reg         <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      count_reg     <= '0;
      done_reg      <= 1'b0;
      dz_reg        <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            d_reg     <= divisor;
            q_reg     <= dividend;
            r_reg     <= '0;
            count_reg <= '0;
            dz_reg    <= 1'b0;
          end
        end
        RUN: begin
          r_reg     <= no_borrow ? trial : r_shift;
          q_reg     <= (q_reg << 1) | N'(no_borrow);
          count_reg <= count_reg + CW'(1);
        end
        FIN: begin
          done_reg <= 1'b1;
          // A zero divisor skipped RUN, so q_reg still holds the original dividend.
          if (d_reg == '0) begin
            quotient_reg  <= '1;
            remainder_reg <= q_reg;
            dz_reg        <= 1'b1;
          end else begin
            quotient_reg  <= q_reg;
            remainder_reg <= r_reg[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_reg == RUN);
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_zxw_seq_div.sv
// Scoreboard bench for zxw_seq_div: stimulus pushes expected results, a monitor checks each done pulse.
module tb_zxw_seq_div;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;

  zxw_seq_div #(.N(N)) dut (
    .clk(clk), .resetn(resetn), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int a; int b; int q; int r; bit dz; int acc;} exp_t;
  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  function automatic void chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("quotient", int'(quotient), e.q);
        chk("remainder", int'(remainder), e.r);
        chk("div_by_zero", int'(div_by_zero), int'(e.dz));
        chk("latency", cyc - e.acc, (e.b != 0) ? N + 1 : 1);
        if (e.b != 0) begin
          chk("invariant", int'(quotient) * e.b + int'(remainder), e.a);
          chk("rem_lt_div", int'(int'(remainder) < e.b), 1);
        end
        $display("div %0d/%0d -> q=%0d r=%0d dz=%0b", e.a, e.b, quotient, remainder, div_by_zero);
      end
    end
  end

  task automatic wait_done(input int b, input bit check_busy);
    int  busy_n;
    bit  seen;
    busy_n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_n++;
    end
    chk("done_seen", int'(seen), 1);
    if (check_busy) chk("busy_cycles", busy_n, (b != 0) ? N : 0);
  endtask

  task automatic do_div(input int a, input int b, input int eq, input int er, input bit edz);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    dividend = N'(a);
    divisor = N'(b);
    @(posedge clk);
    #1;
    e = '{a, b, eq, er, edz, cyc};
    sbq.push_back(e);
    start = 1'b0;
    wait_done(b, 1'b1);
  endtask

  initial begin
    exp_t e;
    bit   seen;
    int   done_n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dz", int'(div_by_zero), 0);
    resetn = 1'b1;

    // Directed vectors
    do_div(13, 4, 3, 1, 1'b0);
    do_div(15, 1, 15, 0, 1'b0);
    do_div(15, 15, 1, 0, 1'b0);
    do_div(3, 7, 0, 3, 1'b0);
    do_div(0, 5, 0, 0, 1'b0);
    do_div(9, 0, 15, 9, 1'b1);
    do_div(8, 2, 4, 0, 1'b0);

    // Start held high with operands churning during RUN/FIN
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd6;
    divisor = 4'd2;
    @(posedge clk);
    #1;
    e = '{6, 2, 3, 0, 1'b0, cyc};
    sbq.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        dividend = N'($urandom_range(15, 0));
        divisor = N'($urandom_range(15, 1));
      end
    end
    chk("hold_done_seen", int'(seen), 1);
    dividend = 4'd10;
    divisor = 4'd3;
    @(posedge clk);
    #1;
    e = '{10, 3, 3, 1, 1'b0, cyc};
    sbq.push_back(e);
    start = 1'b0;
    wait_done(3, 1'b1);

    // Reset during iteration 2 of 14/3
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd14;
    divisor = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_dz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    done_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("abort_no_done", done_n, 0);
    do_div(14, 3, 4, 2, 1'b0);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) do_div(a, b, 15, a, 1'b1);
        else        do_div(a, b, a / b, a % b, 1'b0);
      end
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
